// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The optional FETCH_MISALIGN_EN build adds the FAULT behaviour; its state is always declared here.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        HOLD,
        DRAIN,
        FAULT
    } fetch_state_e;

    localparam logic [1:0] RK_BRANCH = 2'b00;
    localparam logic [1:0] RK_JUMP   = 2'b01;
    localparam logic [1:0] RK_REG    = 2'b10;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_target_calc.sv
// Combinational redirect-target computation (branch / jump / register).
// With FETCH_MISALIGN_EN undefined, register targets are forced word-aligned.
module fetch_target_calc
    import fetch_pkg::*;
(
    input  logic [1:0]  kind_i,
    input  logic [31:0] base_i,
    input  logic [25:0] imm_i,
    output logic [31:0] target_o
);

    always_comb begin
        target_o = base_i;
        case (kind_i)
            RK_BRANCH: target_o = base_i + {{14{imm_i[15]}}, imm_i[15:0], 2'b00};
            RK_JUMP:   target_o = {base_i[31:28], imm_i, 2'b00};
            // Reserved kind 2'b11 behaves as a register redirect.
            default: begin
`ifdef FETCH_MISALIGN_EN
                target_o = base_i;
`else
                target_o = {base_i[31:2], 2'b00};
`endif
            end
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem req/ack handshake, one-entry decode buffer, redirects.
// Define FETCH_MISALIGN_EN to add the fetch_fault output and misaligned-register FAULT state.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4,
    input  logic        redirect_valid,
    input  logic [1:0]  redirect_kind,
    input  logic [31:0] redirect_base,
    input  logic [25:0] redirect_imm
`ifdef FETCH_MISALIGN_EN
    ,
    output logic        fetch_fault
`endif
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic         req_q;
    logic [31:0]  addr_q;
    logic         valid_q;
    logic [31:0]  instr_q;
    logic [31:0]  instr_pc_q;
    logic [31:0]  pc_plus4_q;
    logic [31:0]  target;
    logic         outstanding;

    fetch_target_calc u_target (
        .kind_i   (redirect_kind),
        .base_i   (redirect_base),
        .imm_i    (redirect_imm),
        .target_o (target)
    );

    // A request is still in flight unless memory completes it this very cycle.
    assign outstanding = ((state_q == REQ) || (state_q == DRAIN)) && !imem_ack;

`ifdef FETCH_MISALIGN_EN
    logic fault_q;
    logic pend_fault_q;
    logic misalign;

    assign misalign    = (target[1:0] != 2'b00);
    assign fetch_fault = fault_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            pc_plus4_q <= '0;
`ifdef FETCH_MISALIGN_EN
            fault_q      <= 1'b0;
            pend_fault_q <= 1'b0;
`endif
        end else if (redirect_valid) begin
            pc_q    <= target;
            valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_EN
            pend_fault_q <= misalign && outstanding;
            fault_q      <= misalign && !outstanding;
            if (misalign && !outstanding) begin
                state_q <= FAULT;
                req_q   <= 1'b0;
            end else
`endif
            if (outstanding) begin
                state_q <= DRAIN;
            end else begin
                state_q <= REQ;
                req_q   <= 1'b1;
                addr_q  <= target;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                    addr_q  <= pc_q;
                end
                REQ: begin
                    if (imem_ack) begin
                        instr_q    <= imem_rdata;
                        instr_pc_q <= pc_q;
                        pc_plus4_q <= pc_q + 32'd4;
                        pc_q       <= pc_q + 32'd4;
                        valid_q    <= 1'b1;
                        req_q      <= 1'b0;
                        state_q    <= HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        valid_q <= 1'b0;
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        addr_q  <= pc_q;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
`ifdef FETCH_MISALIGN_EN
                        if (pend_fault_q) begin
                            state_q      <= FAULT;
                            req_q        <= 1'b0;
                            fault_q      <= 1'b1;
                            pend_fault_q <= 1'b0;
                        end else
`endif
                        begin
                            state_q <= REQ;
                            addr_q  <= pc_q;
                        end
                    end
                end
                FAULT: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign pc_plus4    = pc_plus4_q;

endmodule
